neuron_train_ctrl: RTL and testbench

Training sequencer for the single-neuron perceptron. It drives the sample reader's init/next/EOF handshake and computes the neuron response for each sample (X1, X2, T). It owns the weight and bias registers and applies the perceptron learning rule. Epochs repeat until an epoch completes with no weight change, or until MAX_EPOCHS is reached.

---
 rtl/neuron_train_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_neuron_train_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_train_ctrl.sv
// neuron_train_ctrl
//   Training sequencer for a single-neuron perceptron. Drives the sample
//   reader (rd_init/rd_next/rd_eof), evaluates the neuron response for each
//   sample and applies the perceptron learning rule to the weight and bias
//   registers. Epochs repeat until one completes with no weight change or the
//   epoch cap is reached.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle pulse, begins training (ignored while busy/done)
//   rd_init/rd_next 1-cycle strobes to the sample reader
//   rd_eof          reader end-of-file flag
//   x1, x2          signed 7-bit sample inputs
//   t               target: 2'b01 = +1, 2'b11 = -1, others invalid
//   w1, w2, bias    signed WW-bit weights
//   epoch           completed epochs
//   err_cnt         updates made in the current/last epoch
//   busy            training in progress (low in IDLE and DONE)
//   done            1-cycle pulse at end of training
//   converged       valid from done until the next start
module neuron_train_ctrl #(
  parameter int WW          = 8,
  parameter int THETA       = 0,
  parameter int ALPHA_SHIFT = 0,
  parameter int MAX_EPOCHS  = 16,
  parameter int EW          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_init,
  output logic                 rd_next,
  input  logic                 rd_eof,
  input  logic signed [6:0]    x1,
  input  logic signed [6:0]    x2,
  input  logic [1:0]           t,
  output logic signed [WW-1:0] w1,
  output logic signed [WW-1:0] w2,
  output logic signed [WW-1:0] bias,
  output logic [EW-1:0]        epoch,
  output logic [EW-1:0]        err_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 converged
);

  // Neuron input sum width: two WW x 7 products plus bias cannot overflow.
  localparam int YW = WW + 9;
  // Update-sum width: weight plus shifted (and possibly negated) sample.
  localparam int SW = WW + ALPHA_SHIFT + 9;

  localparam logic signed [YW-1:0] TH_POS = YW'(THETA);
  localparam logic signed [YW-1:0] TH_NEG = YW'(-THETA);
  localparam logic signed [SW-1:0] W_MAX  = SW'((2 ** (WW - 1)) - 1);
  localparam logic signed [SW-1:0] W_MIN  = SW'(-(2 ** (WW - 1)));
  localparam logic signed [SW-1:0] B_STEP = SW'(2 ** ALPHA_SHIFT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_COMPUTE,
    S_UPDATE,
    S_NEXT,
    S_CHECK,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t                state_q;
  logic signed [WW-1:0]  w1_q, w2_q, bias_q;
  logic [EW-1:0]         epoch_q, err_q;
  logic                  changed_q;
  logic signed [1:0]     y_q;
  logic                  rd_init_q, rd_next_q;
  logic                  busy_q, done_q, conv_q;

  // Combinational datapath
  logic signed [YW-1:0]  w1_e, w2_e, bias_e, x1_e, x2_e;
  logic signed [YW-1:0]  yin_d;
  logic signed [1:0]     y_d;
  logic signed [SW-1:0]  dx1, dx2, sum1, sum2, sumb;
  logic signed [WW-1:0]  w1_d, w2_d, bias_d;
  logic                  t_valid, mismatch;
  logic [EW-1:0]         err_d, epoch_d;

  function automatic logic signed [WW-1:0] sat_w(input logic signed [SW-1:0] v);
    logic signed [WW-1:0] r;
    if (v > W_MAX)      r = W_MAX[WW-1:0];
    else if (v < W_MIN) r = W_MIN[WW-1:0];
    else                r = v[WW-1:0];
    return r;
  endfunction

  assign w1_e   = YW'(w1_q);
  assign w2_e   = YW'(w2_q);
  assign bias_e = YW'(bias_q);
  assign x1_e   = YW'(x1);
  assign x2_e   = YW'(x2);
  assign yin_d  = w1_e * x1_e + w2_e * x2_e + bias_e;

  always_comb begin
    y_d = 2'sb00;
    if (yin_d > TH_POS)      y_d = 2'sb01;
    else if (yin_d < TH_NEG) y_d = 2'sb11;
  end

  // Valid target codes are exactly the 2-bit two's complement of +1/-1,
  // so the registered response compares against t directly.
  assign t_valid  = (t == 2'b01) || (t == 2'b11);
  assign mismatch = t_valid && (y_q != $signed(t));

  assign dx1  = SW'(x1) <<< ALPHA_SHIFT;
  assign dx2  = SW'(x2) <<< ALPHA_SHIFT;
  assign sum1 = SW'(w1_q)   + (t[1] ? -dx1    : dx1);
  assign sum2 = SW'(w2_q)   + (t[1] ? -dx2    : dx2);
  assign sumb = SW'(bias_q) + (t[1] ? -B_STEP : B_STEP);

  assign w1_d   = sat_w(sum1);
  assign w2_d   = sat_w(sum2);
  assign bias_d = sat_w(sumb);

  assign err_d   = (&err_q) ? err_q : err_q + EW'(1);
  assign epoch_d = epoch_q + EW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w1_q      <= '0;
      w2_q      <= '0;
      bias_q    <= '0;
      epoch_q   <= '0;
      err_q     <= '0;
      changed_q <= 1'b0;
      y_q       <= '0;
      rd_init_q <= 1'b0;
      rd_next_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
    end else begin
      // Strobes are registered: set on entry to LOAD/NEXT/DONE, cleared otherwise.
      rd_init_q <= 1'b0;
      rd_next_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            w1_q      <= '0;
            w2_q      <= '0;
            bias_q    <= '0;
            epoch_q   <= '0;
            conv_q    <= 1'b0;
            busy_q    <= 1'b1;
            rd_init_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          err_q     <= '0;
          changed_q <= 1'b0;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          y_q     <= y_d;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          if (mismatch) begin
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            bias_q    <= bias_d;
            err_q     <= err_d;
            changed_q <= 1'b1;
          end
          rd_next_q <= 1'b1;
          state_q   <= S_NEXT;
        end
        S_NEXT: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          state_q <= rd_eof ? S_EPOCH_END : S_COMPUTE;
        end
        S_EPOCH_END: begin
          epoch_q <= epoch_d;
          if (!changed_q) begin
            conv_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (epoch_d == EW'(MAX_EPOCHS)) begin
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rd_init_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_init   = rd_init_q;
  assign rd_next   = rd_next_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign bias      = bias_q;
  assign epoch     = epoch_q;
  assign err_cnt   = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Self-checking bench for neuron_train_ctrl. Two instances: ALPHA_SHIFT=0 and
// ALPHA_SHIFT=1, both with MAX_EPOCHS=4. A behavioural sample reader feeds
// the selected instance; a perceptron model computes per-epoch results.
module tb_neuron_train_ctrl;

  localparam int TB_THETA = 0;
  localparam int TB_MAXEP = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v;
  logic rd_eof;
  logic signed [6:0] x1, x2;
  logic [1:0] t;

  logic rd_init_v [2];
  logic rd_next_v [2];
  logic busy_v [2];
  logic done_v [2];
  logic conv_v [2];
  logic signed [7:0] w1_v [2];
  logic signed [7:0] w2_v [2];
  logic signed [7:0] b_v [2];
  logic [7:0] ep_v [2];
  logic [7:0] err_v [2];

  logic sel;
  logic rd_init_s, rd_next_s, busy_s, done_s, conv_s;
  logic signed [7:0] w1_s, w2_s, b_s;
  logic [7:0] ep_s, err_s;

  always #5 clk = ~clk;

  neuron_train_ctrl #(.WW(8), .THETA(TB_THETA), .ALPHA_SHIFT(0), .MAX_EPOCHS(TB_MAXEP), .EW(8)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .rd_init(rd_init_v[0]), .rd_next(rd_next_v[0]),
    .rd_eof(rd_eof), .x1(x1), .x2(x2), .t(t), .w1(w1_v[0]), .w2(w2_v[0]), .bias(b_v[0]),
    .epoch(ep_v[0]), .err_cnt(err_v[0]), .busy(busy_v[0]), .done(done_v[0]), .converged(conv_v[0])
  );

  neuron_train_ctrl #(.WW(8), .THETA(TB_THETA), .ALPHA_SHIFT(1), .MAX_EPOCHS(TB_MAXEP), .EW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .rd_init(rd_init_v[1]), .rd_next(rd_next_v[1]),
    .rd_eof(rd_eof), .x1(x1), .x2(x2), .t(t), .w1(w1_v[1]), .w2(w2_v[1]), .bias(b_v[1]),
    .epoch(ep_v[1]), .err_cnt(err_v[1]), .busy(busy_v[1]), .done(done_v[1]), .converged(conv_v[1])
  );

  assign rd_init_s = sel ? rd_init_v[1] : rd_init_v[0];
  assign rd_next_s = sel ? rd_next_v[1] : rd_next_v[0];
  assign busy_s    = sel ? busy_v[1]    : busy_v[0];
  assign done_s    = sel ? done_v[1]    : done_v[0];
  assign conv_s    = sel ? conv_v[1]    : conv_v[0];
  assign w1_s      = sel ? w1_v[1]      : w1_v[0];
  assign w2_s      = sel ? w2_v[1]      : w2_v[0];
  assign b_s       = sel ? b_v[1]       : b_v[0];
  assign ep_s      = sel ? ep_v[1]      : ep_v[0];
  assign err_s     = sel ? err_v[1]     : err_v[0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Sample file
  int s_x1 [8];
  int s_x2 [8];
  logic [1:0] s_t [8];
  int nsamp = 0;
  int ridx = 0;

  task automatic add_sample(input int a, input int b, input logic [1:0] tt);
    s_x1[nsamp] = a;
    s_x2[nsamp] = b;
    s_t[nsamp]  = tt;
    nsamp++;
  endtask

  task automatic load_and();
    nsamp = 0;
    add_sample( 1,  1, 2'b01);
    add_sample( 1, -1, 2'b11);
    add_sample(-1,  1, 2'b11);
    add_sample(-1, -1, 2'b11);
  endtask

  task automatic drive_sample();
    if (ridx < nsamp) begin
      x1 = 7'(s_x1[ridx]);
      x2 = 7'(s_x2[ridx]);
      t  = s_t[ridx];
      rd_eof = 1'b0;
    end else begin
      rd_eof = 1'b1;
    end
  endtask

  // Reader: responds on the edge that samples a strobe, data valid next cycle.
  initial begin
    logic ri, rn;
    forever begin
      @(negedge clk);
      ri = rd_init_s;
      rn = rd_next_s;
      @(posedge clk);
      #1;
      if (ri) begin
        ridx = 0;
        drive_sample();
      end else if (rn) begin
        ridx++;
        drive_sample();
      end
    end
  end

  // Perceptron model: per-epoch weights and error counts
  int exp_w1 [17];
  int exp_w2 [17];
  int exp_b  [17];
  int exp_err [17];
  int exp_conv, exp_final;

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic compute_model(input int alpha, input int maxep);
    int a1, a2, ab, errs, yin, y, tv;
    a1 = 0; a2 = 0; ab = 0;
    exp_conv = 0;
    exp_final = maxep;
    for (int e = 1; e <= maxep; e++) begin
      errs = 0;
      for (int i = 0; i < nsamp; i++) begin
        yin = a1 * s_x1[i] + a2 * s_x2[i] + ab;
        y = (yin > TB_THETA) ? 1 : ((yin < -TB_THETA) ? -1 : 0);
        tv = (s_t[i] == 2'b01) ? 1 : ((s_t[i] == 2'b11) ? -1 : 0);
        if (tv != 0 && y != tv) begin
          a1 = sat8(a1 + tv * s_x1[i] * (1 << alpha));
          a2 = sat8(a2 + tv * s_x2[i] * (1 << alpha));
          ab = sat8(ab + tv * (1 << alpha));
          errs = (errs < 255) ? errs + 1 : 255;
        end
      end
      exp_w1[e] = a1; exp_w2[e] = a2; exp_b[e] = ab; exp_err[e] = errs;
      if (errs == 0) begin
        exp_conv = 1;
        exp_final = e;
        break;
      end
    end
  endtask

  // Compare process
  bit checking = 0;
  int seen_epoch = 0;
  int init_cnt = 0;
  int done_cnt = 0;
  int cap_w1 = 0, cap_w2 = 0, cap_b = 0, cap_err = 0;

  initial begin
    logic p_init, p_next;
    logic [7:0] p_epoch;
    int e;
    p_init = 1'b0; p_next = 1'b0; p_epoch = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_init_s) init_cnt++;
        if (done_s) done_cnt++;
        if (rd_init_s || rd_next_s) begin
          chk("strobe_exclusive", int'(rd_init_s & rd_next_s), 0);
          chk("strobe_back_to_back", int'(p_init | p_next), 0);
        end
        if (checking && ep_s != p_epoch && ep_s != 8'd0) begin
          e = int'(ep_s);
          chk("epoch_step", e, seen_epoch + 1);
          if (e <= 16) begin
            chk("epoch_w1", int'(w1_s), exp_w1[e]);
            chk("epoch_w2", int'(w2_s), exp_w2[e]);
            chk("epoch_bias", int'(b_s), exp_b[e]);
            chk("epoch_err_cnt", int'(err_s), exp_err[e]);
          end
          if (e == 1) begin
            cap_w1 = int'(w1_s); cap_w2 = int'(w2_s);
            cap_b = int'(b_s); cap_err = int'(err_s);
          end
          seen_epoch = e;
        end
        if (checking && done_s) begin
          chk("done_busy_low", int'(busy_s), 0);
          chk("done_converged", int'(conv_s), exp_conv);
          chk("done_epoch", int'(ep_s), exp_final);
          chk("done_w1", int'(w1_s), exp_w1[exp_final]);
          chk("done_w2", int'(w2_s), exp_w2[exp_final]);
          chk("done_bias", int'(b_s), exp_b[exp_final]);
        end
      end
      p_init = rd_init_s;
      p_next = rd_next_s;
      p_epoch = ep_s;
    end
  end

  task automatic run_train(input int which, input int alpha, input bit mid_start);
    bit got;
    checking = 0;
    sel = (which != 0);
    @(negedge clk);
    @(posedge clk);
    compute_model(alpha, TB_MAXEP);
    seen_epoch = 0;
    init_cnt = 0;
    checking = 1;
    #1 start_v[which] = 1'b1;
    @(negedge clk);
    chk("rd_init_before_edge", int'(rd_init_s), 0);
    @(posedge clk);
    #1 start_v[which] = 1'b0;
    @(negedge clk);
    chk("rd_init_latency", int'(rd_init_s), 1);
    if (mid_start) begin
      repeat (10) @(posedge clk);
      #1 start_v[which] = 1'b1;
      @(posedge clk);
      #1 start_v[which] = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_s) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", int'(got), 1);
    if (got) begin
      // start during the DONE cycle must not launch a new run
      start_v[which] = 1'b1;
      @(posedge clk);
      #1 start_v[which] = 1'b0;
      @(negedge clk);
      chk("start_in_done_busy", int'(busy_s), 0);
      chk("start_in_done_rd_init", int'(rd_init_s), 0);
      repeat (3) @(negedge clk);
      chk("hold_w1", int'(w1_s), exp_w1[exp_final]);
      chk("hold_epoch", int'(ep_s), exp_final);
      chk("hold_converged", int'(conv_s), exp_conv);
    end
    checking = 0;
  endtask

  initial begin
    bit got;
    int base;
    rst = 1'b1; start_v = '0; sel = 1'b0;
    x1 = '0; x2 = '0; t = '0; rd_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", int'(busy_v[d]), 0);
      chk("reset_done", int'(done_v[d]), 0);
      chk("reset_conv", int'(conv_v[d]), 0);
      chk("reset_rd_init", int'(rd_init_v[d]), 0);
      chk("reset_rd_next", int'(rd_next_v[d]), 0);
      chk("reset_w1", int'(w1_v[d]), 0);
      chk("reset_w2", int'(w2_v[d]), 0);
      chk("reset_bias", int'(b_v[d]), 0);
      chk("reset_epoch", int'(ep_v[d]), 0);
      chk("reset_err", int'(err_v[d]), 0);
    end

    // AND set
    load_and();
    run_train(0, 0, 1'b0);
    chk("and_e1_w1", cap_w1, 1);
    chk("and_e1_w2", cap_w2, 1);
    chk("and_e1_bias", cap_b, -1);
    chk("and_e1_err", cap_err, 3);
    chk("and_w1", int'(w1_s), 1);
    chk("and_w2", int'(w2_s), 1);
    chk("and_bias", int'(b_s), -1);
    chk("and_epoch", int'(ep_s), 2);
    chk("and_conv", int'(conv_s), 1);
    chk("and_err", int'(err_s), 0);

    // XOR set: never separable, stops at the epoch cap
    nsamp = 0;
    add_sample( 1,  1, 2'b11);
    add_sample( 1, -1, 2'b01);
    add_sample(-1,  1, 2'b01);
    add_sample(-1, -1, 2'b11);
    run_train(0, 0, 1'b0);
    chk("xor_epoch", int'(ep_s), 4);
    chk("xor_conv", int'(conv_s), 0);
    chk("xor_rd_init_pulses", init_cnt, 4);

    // Saturation on the ALPHA_SHIFT=1 instance: -1 * -64 * 2 = 128 -> 127
    nsamp = 0;
    add_sample(-64, 63, 2'b11);
    run_train(1, 1, 1'b0);
    chk("sat_e1_w1", cap_w1, 127);
    chk("sat_e1_w2", cap_w2, -126);
    chk("sat_e1_bias", cap_b, -2);
    chk("sat_e1_err", cap_err, 1);
    chk("sat_epoch", int'(ep_s), 2);
    chk("sat_conv", int'(conv_s), 1);

    // Invalid target sample appended, plus a start pulse while busy
    load_and();
    add_sample(5, 5, 2'b00);
    run_train(0, 0, 1'b1);
    chk("inv_e1_err", cap_err, 3);
    chk("inv_w1", int'(w1_s), 1);
    chk("inv_w2", int'(w2_s), 1);
    chk("inv_bias", int'(b_s), -1);
    chk("inv_epoch", int'(ep_s), 2);
    chk("inv_conv", int'(conv_s), 1);

    // Reset during COMPUTE of the second sample of epoch 1
    load_and();
    sel = 1'b0;
    checking = 0;
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_next_s) begin
        got = 1;
        break;
      end
    end
    chk("rst_reached_next", int'(got), 1);
    @(negedge clk);
    chk("pre_rst_w1", int'(w1_s), 1);
    chk("pre_rst_busy", int'(busy_s), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy_s), 0);
    chk("post_rst_w1", int'(w1_s), 0);
    chk("post_rst_w2", int'(w2_s), 0);
    chk("post_rst_bias", int'(b_s), 0);
    chk("post_rst_epoch", int'(ep_s), 0);
    base = done_cnt;
    repeat (100) @(negedge clk);
    chk("post_rst_no_done", done_cnt - base, 0);
    chk("post_rst_idle", int'(busy_s), 0);

    // Fresh start after the aborted run
    run_train(0, 0, 1'b0);
    chk("restart_w1", int'(w1_s), 1);
    chk("restart_conv", int'(conv_s), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
